rx_beam_summer: RTL and testbench



---
 rtl/beam_pkg.sv | 38 +++
 rtl/beam_ring_ram.sv | 22 ++
 rtl/rx_beam_summer.sv | 127 ++++++++++++
 tb/tb_rx_beam_summer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/beam_pkg.sv
// rtl/beam_pkg.sv - shared constants, FSM type and steering delay helper for the receive beamformer
package beam_pkg;

    localparam int NUM_CH     = 20;
    localparam int RING_DEPTH = 256;
    localparam int ADDR_W     = 8;

    // Steering step in samples for |angle index| 1..6, entry 0 is index 1
    localparam logic [5:0][3:0] STEP_TABLE = {4'd13, 4'd11, 4'd9, 4'd7, 4'd4, 4'd2};

    localparam logic [3:0] SEL_ZERO    = 4'd6;
    localparam logic [3:0] SEL_POS_MIN = 4'd7;
    localparam logic [3:0] SEL_POS_MAX = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_ACCUM,
        ST_DONE
    } beam_state_t;

    // Positive angles delay the high channels, negative angles the low ones
    function automatic logic [7:0] chan_delay(input logic [3:0] sel, input logic [4:0] ch);
        logic [7:0] step;
        logic [7:0] mult;
        step = '0;
        mult = '0;
        if (sel >= SEL_POS_MIN && sel <= SEL_POS_MAX) begin
            step = {4'd0, STEP_TABLE[3'(sel - SEL_POS_MIN)]};
            mult = {3'd0, ch};
        end else if (sel < SEL_ZERO) begin
            step = {4'd0, STEP_TABLE[3'(SEL_ZERO - 4'd1 - sel)]};
            mult = 8'(NUM_CH - 1) - {3'd0, ch};
        end
        return step * mult;
    endfunction

endpackage

// File: rtl/beam_ring_ram.sv
// rtl/beam_ring_ram.sv - 256 x NUM_CH simple dual-port sample ring, synchronous read
module beam_ring_ram
    import beam_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NUM_CH-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [NUM_CH-1:0] rd_data
);

    logic [NUM_CH-1:0] mem [RING_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/rx_beam_summer.sv
// rtl/rx_beam_summer.sv - delay-and-sum receive beamformer over a 256-sample ring of element bits
module rx_beam_summer
    import beam_pkg::*;
#(
    parameter int SAMPLE_DIV = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sample_in,
    input  logic [3:0]        select,
    output logic [4:0]        sum_out,
    output logic              sum_valid
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);

    logic [NUM_CH-1:0] samp_s1, samp_s2;
    logic [3:0]        sel_s1, sel_s2;
    logic [CNT_W-1:0]  div_cnt;
    beam_state_t       state, state_nxt;
    logic [4:0]        ch, ch_d;
    logic [7:0]        wr_ptr;
    logic [8:0]        fill;
    logic [3:0]        sel_q;
    logic [4:0]        acc;
    logic              acc_en;
    logic              wr_en;
    logic              issue;
    logic [7:0]        cur_delay;
    logic [7:0]        rd_addr;
    logic [NUM_CH-1:0] rd_data;

    // Inputs are asynchronous; the synchronizers need no reset
    always_ff @(posedge clk) begin
        samp_s1 <= sample_in;
        samp_s2 <= samp_s1;
        sel_s1  <= select;
        sel_s2  <= sel_s1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == CNT_W'(SAMPLE_DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (div_cnt == '0) state_nxt = ST_READ;
            ST_READ:  if (ch == 5'(NUM_CH - 1)) state_nxt = ST_ACCUM;
            ST_ACCUM: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_en     = (state == ST_IDLE) && (div_cnt == '0);
        issue     = (state == ST_READ);
        cur_delay = chan_delay(sel_q, ch);
        rd_addr   = wr_ptr - cur_delay;
    end

    beam_ring_ram u_ring (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (samp_s2),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The current sample is already in the ring while fill still excludes it, hence <=
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            fill      <= '0;
            acc       <= '0;
            sel_q     <= SEL_ZERO;
            ch        <= '0;
            ch_d      <= '0;
            acc_en    <= 1'b0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            acc_en    <= issue && ({1'b0, cur_delay} <= fill);
            ch_d      <= ch;
            case (state)
                ST_IDLE: begin
                    if (div_cnt == '0) begin
                        sel_q <= sel_s2;
                        acc   <= '0;
                        ch    <= '0;
                    end
                end
                ST_READ: ch <= ch + 1'b1;
                ST_DONE: begin
                    sum_out   <= acc;
                    sum_valid <= 1'b1;
                    wr_ptr    <= wr_ptr + 1'b1;
                    if (fill != 9'(RING_DEPTH)) begin
                        fill <= fill + 1'b1;
                    end
                end
                default: ;
            endcase
            if (acc_en && rd_data[ch_d]) begin
                acc <= acc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_beam_summer.sv
// tb/tb_rx_beam_summer.sv - directed self-checking bench for rx_beam_summer
module tb_rx_beam_summer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] sample_in = '0;
    logic [3:0]  select = 4'd6;
    logic [4:0]  sum_out;
    logic        sum_valid;

    always #5 clk = ~clk;

    rx_beam_summer #(.SAMPLE_DIV(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_in (sample_in),
        .select    (select),
        .sum_out   (sum_out),
        .sum_valid (sum_valid)
    );

    typedef struct {
        int scen;
        int k;
        int exp;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   sums [600];
    int   period_bad;
    vec_t vecs [$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // pat 0: all ones, 1: all-ones impulse at sample 300, 2: element 19 only, else zeros
    function automatic logic [19:0] pat_val(input int pat, input int k);
        case (pat)
            0:       return 20'hFFFFF;
            1:       return (k == 300) ? 20'hFFFFF : 20'h0;
            2:       return 20'h80000;
            default: return 20'h0;
        endcase
    endfunction

    task automatic do_reset(input logic [19:0] v, input logic [3:0] s);
        @(negedge clk);
        rst       = 1'b1;
        sample_in = v;
        select    = s;
        repeat (4) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_valid(output int s, output bit ok, output int cyc);
        ok  = 1'b0;
        s   = -1;
        cyc = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            cyc++;
            if (sum_valid) begin
                s  = int'(sum_out);
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_scen(input int scen, input logic [3:0] sel, input int pat, input int n);
        int s, cyc;
        bit ok;
        do_reset(pat_val(pat, 0), sel);
        period_bad = 0;
        for (int k = 0; k < n; k++) begin
            wait_valid(s, ok, cyc);
            sums[k] = s;
            if (!ok) begin
                check($sformatf("timeout_s%0d_k%0d", scen, k), 0, 1);
                break;
            end
            if (k > 0 && cyc != 32) period_bad++;
            sample_in = pat_val(pat, k + 1);
        end
        check($sformatf("period_s%0d", scen), period_bad, 0);
        foreach (vecs[i]) begin
            if (vecs[i].scen == scen) begin
                check($sformatf("sum_s%0d_k%0d", scen, vecs[i].k), sums[vecs[i].k], vecs[i].exp);
            end
        end
    endtask

    task automatic check_impulse(input int scen, input int n, input bit broadside);
        int exp;
        for (int k = 0; k < n; k++) begin
            if (broadside) exp = (k == 300) ? 20 : 0;
            else exp = (k >= 300 && k <= 547 && ((k - 300) % 13) == 0) ? 1 : 0;
            check($sformatf("impulse_s%0d_k%0d", scen, k), sums[k], exp);
        end
    endtask

    initial begin
        int s, cyc, seen;
        bit ok;

        // fill ramp, select 12 (step 13, +30 deg)
        vecs.push_back('{0, 0, 1});   vecs.push_back('{0, 1, 1});
        vecs.push_back('{0, 12, 1});  vecs.push_back('{0, 13, 2});
        vecs.push_back('{0, 25, 2});  vecs.push_back('{0, 26, 3});
        vecs.push_back('{0, 130, 11}); vecs.push_back('{0, 246, 19});
        vecs.push_back('{0, 247, 20}); vecs.push_back('{0, 259, 20});
        // broadside all ones
        vecs.push_back('{1, 0, 20});  vecs.push_back('{1, 100, 20});
        vecs.push_back('{1, 269, 20});
        // element 19 alone: -30 deg gives it delay 0, +30 deg delay 247
        vecs.push_back('{7, 0, 1});   vecs.push_back('{7, 11, 1});
        vecs.push_back('{8, 0, 0});   vecs.push_back('{8, 11, 0});
        // remaining step table entries during fill
        vecs.push_back('{9, 0, 1});   vecs.push_back('{9, 6, 1});
        vecs.push_back('{9, 7, 2});   vecs.push_back('{9, 14, 3});
        vecs.push_back('{10, 0, 1});  vecs.push_back('{10, 3, 1});
        vecs.push_back('{10, 4, 2});  vecs.push_back('{10, 15, 4});
        vecs.push_back('{11, 0, 1});  vecs.push_back('{11, 8, 1});
        vecs.push_back('{11, 9, 2});
        vecs.push_back('{12, 0, 1});  vecs.push_back('{12, 10, 1});
        vecs.push_back('{12, 11, 2});
        vecs.push_back('{13, 1, 1});  vecs.push_back('{13, 2, 2});
        vecs.push_back('{13, 15, 8});
        vecs.push_back('{14, 0, 20}); vecs.push_back('{14, 15, 20});

        repeat (4) @(negedge clk);
        check("reset_sum_out", int'(sum_out), 0);
        check("reset_sum_valid", int'(sum_valid), 0);

        run_scen(0, 4'd12, 0, 260);
        run_scen(7, 4'd0, 2, 12);
        run_scen(8, 4'd12, 2, 12);
        run_scen(9, 4'd3, 0, 16);
        run_scen(10, 4'd8, 0, 16);
        run_scen(11, 4'd10, 0, 16);
        run_scen(12, 4'd1, 0, 16);
        run_scen(13, 4'd5, 0, 16);
        run_scen(14, 4'd13, 0, 16);

        run_scen(2, 4'd12, 1, 560);
        check_impulse(2, 560, 1'b0);
        run_scen(3, 4'd0, 1, 560);
        check_impulse(3, 560, 1'b0);
        run_scen(4, 4'd15, 1, 310);
        check_impulse(4, 310, 1'b1);

        // select change mid-frame only applies from the next sample tick
        do_reset(20'hFFFFF, 4'd6);
        repeat (10) @(posedge clk);
        #1 select = 4'd12;
        wait_valid(s, ok, cyc);
        check("toggle_frame0", s, 20);
        wait_valid(s, ok, cyc);
        check("toggle_frame1", s, 1);
        wait_valid(s, ok, cyc);
        check("toggle_frame2", s, 1);

        // ring full of ones, then reset at div_cnt 12 with zero input
        run_scen(1, 4'd6, 0, 270);
        sample_in = 20'h0;
        select    = 4'd12;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_sum_out", int'(sum_out), 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (sum_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        for (int k = 0; k < 30; k++) begin
            wait_valid(s, ok, cyc);
            check($sformatf("stale_mask_k%0d", k), s, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
